// File: rtl/ddr_traffic_gen.sv
// ddr_traffic_gen: DDR3 write-then-read sweep generator with address-derived
// data and in-order read-back checking. Sweeps col, then row, bank, rank.
// Optional feature: define TG_AUTO_PRE_EN to set auto_pre on the last column
// of every row; left undefined, auto_pre stays 0 and the controller precharges.
module ddr_traffic_gen #(
  parameter int          DATA_W      = 128,
  parameter int          RANK_NUM    = 1,
  parameter int          BANK_NUM    = 1,
  parameter int          ROW_NUM     = 32,
  parameter int          COL_NUM     = 1024,
  parameter int          COL_STEP    = 8,
  parameter logic [31:0] SEED        = 32'hA5A5_0000,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              power_on_rst_n,
  input  logic              start,
  input  logic [7:0]        ba_cmd_pm,
  output logic [33:0]       command,
  output logic              valid,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_data_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       error_cnt,
  output logic [31:0]       first_err_idx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [31:0] N_CMD     = 32'(RANK_NUM * BANK_NUM * ROW_NUM * (COL_NUM / COL_STEP));
  localparam logic [9:0]  LAST_COL  = 10'(COL_NUM - COL_STEP);
  localparam logic [9:0]  COL_INC   = 10'(COL_STEP);
  localparam logic [12:0] LAST_ROW  = 13'(ROW_NUM - 1);
  localparam logic [2:0]  LAST_BANK = 3'(BANK_NUM - 1);
  localparam logic [1:0]  LAST_RANK = 2'(RANK_NUM - 1);
  localparam logic [31:0] TO_LIM    = 32'(TIMEOUT_CYC);
  localparam int          NW        = (DATA_W + 31) / 32;

  // Beat pattern for index idx: 32-bit words w, w+1, w+2, w+3 repeating upward.
  function automatic logic [DATA_W-1:0] gen_data(input logic [31:0] idx);
    logic [NW*32-1:0] v;
    logic [31:0]      w;
    w = SEED ^ idx;
    v = '0;
    for (int j = 0; j < NW; j++) begin
      v[j*32 +: 32] = w + 32'(j % 4);
    end
    return v[DATA_W-1:0];
  endfunction

  logic [2:0]        r_state;
  logic [9:0]        r_col;
  logic [12:0]       r_row;
  logic [2:0]        r_bank;
  logic [1:0]        r_rank;
  logic [31:0]       r_k;
  logic              r_valid;
  logic [33:0]       r_command;
  logic [DATA_W-1:0] r_write_data;
  logic [31:0]       r_rx_cnt;
  logic [31:0]       r_idle_cnt;
  logic [15:0]       r_err_cnt;
  logic [31:0]       r_first_err;
  logic              r_timeout;
  logic              r_done;
  logic              r_pass;

  logic        w_start_ok;
  logic        w_issue;
  logic        w_phase_last;
  logic        w_rw;
  logic        w_auto_pre;
  logic        w_beat_ok;
  logic        w_mismatch;
  logic        w_err_inc;
  logic [15:0] w_err_next;
  logic        w_drain_ok;
  logic        w_drain_to;
  logic        w_finish;

  assign w_start_ok   = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_issue      = (r_state == S_WRITE || r_state == S_READ) && ba_cmd_pm[r_bank];
  assign w_phase_last = (r_col == LAST_COL) && (r_row == LAST_ROW) &&
                        (r_bank == LAST_BANK) && (r_rank == LAST_RANK);
  assign w_rw         = (r_state == S_READ);

`ifdef TG_AUTO_PRE_EN
  assign w_auto_pre = (r_col == LAST_COL);
`else
  assign w_auto_pre = 1'b0;
`endif

  // Returns are in issue order, so r_rx_cnt names the index each beat must match.
  assign w_beat_ok  = read_data_valid && (r_state == S_READ || r_state == S_DRAIN) &&
                      (r_rx_cnt != N_CMD);
  assign w_mismatch = w_beat_ok && (read_data != gen_data(r_rx_cnt));
  assign w_err_inc  = read_data_valid && (!w_beat_ok || w_mismatch);
  assign w_err_next = (w_err_inc && r_err_cnt != 16'hFFFF) ? r_err_cnt + 16'd1 : r_err_cnt;
  assign w_drain_ok = (r_state == S_DRAIN) && (r_rx_cnt == N_CMD);
  assign w_drain_to = (r_state == S_DRAIN) && !w_drain_ok && (r_idle_cnt == TO_LIM);
  assign w_finish   = w_drain_ok || w_drain_to;

  // Phase sequencing, address sweep and one-cycle command issue.
  always_ff @(posedge clk) begin
    if (!power_on_rst_n) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_bank       <= '0;
      r_rank       <= '0;
      r_k          <= '0;
      r_valid      <= 1'b0;
      r_command    <= '0;
      r_write_data <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) r_state <= S_WRITE;
        S_WRITE:        if (w_issue && w_phase_last) r_state <= S_READ;
        S_READ:         if (w_issue && w_phase_last) r_state <= S_DRAIN;
        S_DRAIN:        if (w_finish) r_state <= S_DONE;
        default:        r_state <= S_IDLE;
      endcase

      if (w_start_ok) begin
        r_col  <= '0;
        r_row  <= '0;
        r_bank <= '0;
        r_rank <= '0;
        r_k    <= '0;
      end else if (w_issue) begin
        r_k <= w_phase_last ? 32'd0 : r_k + 32'd1;
        if (r_col != LAST_COL) begin
          r_col <= r_col + COL_INC;
        end else begin
          r_col <= '0;
          if (r_row != LAST_ROW) begin
            r_row <= r_row + 13'd1;
          end else begin
            r_row <= '0;
            if (r_bank != LAST_BANK) begin
              r_bank <= r_bank + 3'd1;
            end else begin
              r_bank <= '0;
              r_rank <= (r_rank == LAST_RANK) ? 2'd0 : r_rank + 2'd1;
            end
          end
        end
      end

      r_valid      <= w_issue;
      r_command    <= w_issue ? {r_rank, w_rw, 1'b0, r_row, 1'b0, 1'b1, 1'b0,
                                 w_auto_pre, r_col, r_bank} : 34'd0;
      r_write_data <= (w_issue && !w_rw) ? gen_data(r_k) : '0;
    end
  end

  // Read-back checking, drain watchdog and final pass/fail status.
  always_ff @(posedge clk) begin
    if (!power_on_rst_n) begin
      r_rx_cnt    <= '0;
      r_idle_cnt  <= '0;
      r_err_cnt   <= '0;
      r_first_err <= 32'hFFFF_FFFF;
      r_timeout   <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else if (w_start_ok) begin
      r_rx_cnt    <= '0;
      r_idle_cnt  <= '0;
      r_err_cnt   <= '0;
      r_first_err <= 32'hFFFF_FFFF;
      r_timeout   <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_err_cnt <= w_err_next;
      if (w_mismatch && r_first_err == 32'hFFFF_FFFF) r_first_err <= r_rx_cnt;
      if (w_beat_ok) r_rx_cnt <= r_rx_cnt + 32'd1;
      r_idle_cnt <= (read_data_valid || r_state != S_DRAIN) ? 32'd0 : r_idle_cnt + 32'd1;
      if (w_drain_to) r_timeout <= 1'b1;
      if (w_finish) begin
        r_done <= 1'b1;
        r_pass <= (w_err_next == 16'd0) && !w_drain_to;
      end else if (r_state == S_DONE && w_err_inc) begin
        r_pass <= 1'b0;
      end
    end
  end

  assign command       = r_command;
  assign valid         = r_valid;
  assign write_data    = r_write_data;
  assign busy          = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_DRAIN);
  assign done          = r_done;
  assign pass          = r_pass;
  assign timeout       = r_timeout;
  assign error_cnt     = r_err_cnt;
  assign first_err_idx = r_first_err;

endmodule

// File: tb/tb_ddr_traffic_gen.sv
// Bench for ddr_traffic_gen: loopback memory model with randomized bank-ready
// masks and return latency; expected commands/data come from index arithmetic.
module tb_ddr_traffic_gen;

  localparam int          DW     = 128;
  localparam int          RN     = 1;
  localparam int          BN     = 2;
  localparam int          WN     = 2;
  localparam int          CN     = 32;
  localparam int          CS     = 8;
  localparam int          TO     = 4096;
  localparam logic [31:0] SEED_V = 32'hA5A5_0000;
  localparam int          N      = RN * BN * WN * (CN / CS);
  localparam logic [33:0] K5_CMD = {2'd0, 1'b0, 1'b0, 13'd1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd8, 3'd0};

  logic          clk = 1'b0;
  logic          power_on_rst_n;
  logic          start;
  logic [7:0]    ba_cmd_pm;
  logic [33:0]   command;
  logic          valid;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          read_data_valid;
  logic          busy, done, pass, timeout;
  logic [15:0]   error_cnt;
  logic [31:0]   first_err_idx;

  always #5 clk = ~clk;

  ddr_traffic_gen #(
    .DATA_W(DW), .RANK_NUM(RN), .BANK_NUM(BN), .ROW_NUM(WN), .COL_NUM(CN),
    .COL_STEP(CS), .SEED(SEED_V), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .power_on_rst_n(power_on_rst_n), .start(start), .ba_cmd_pm(ba_cmd_pm),
    .command(command), .valid(valid), .write_data(write_data), .read_data(read_data),
    .read_data_valid(read_data_valid), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .error_cnt(error_cnt), .first_err_idx(first_err_idx)
  );

  typedef struct {
    int           due;
    logic [127:0] d;
  } resp_t;

  int n_vec = 0;
  int n_err = 0;

  int  cmd_seen     = 0;
  int  beats_out    = 0;
  int  cyc          = 0;
  int  last_rdv_cyc = 0;
  int  pm_mode      = 0;
  int  flip_beat    = -1;
  bit  drop_last    = 1'b0;
  bit  inject_spur  = 1'b0;
  logic [7:0]   pm_applied;
  logic [127:0] mem [int];
  resp_t        q [$];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_data(input int k);
    logic [31:0] w;
    w = SEED_V ^ 32'(k);
    return {w + 32'd3, w + 32'd2, w + 32'd1, w};
  endfunction

  function automatic logic [33:0] exp_cmd(input int k, input bit rd);
    int cpr, col, row, bank, rank;
    bit ap;
    cpr  = CN / CS;
    col  = (k % cpr) * CS;
    row  = (k / cpr) % WN;
    bank = (k / (cpr * WN)) % BN;
    rank = k / (cpr * WN * BN);
`ifdef TG_AUTO_PRE_EN
    ap = (col == CN - CS);
`else
    ap = 1'b0;
`endif
    return {2'(rank), rd, 1'b0, 13'(row), 1'b0, 1'b1, 1'b0, ap, 10'(col), 3'(bank)};
  endfunction

  // Memory/controller model: checks issued commands, stores writes, returns reads.
  initial begin : responder
    logic [33:0] ec;
    resp_t       r;
    int          key;
    int          k;
    int          lat;
    bit          rdf;
    ba_cmd_pm       = 8'hFF;
    pm_applied      = 8'hFF;
    read_data_valid = 1'b0;
    read_data       = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (valid) begin
        if (cmd_seen >= 2 * N) begin
          check_val("cmd_count", 128'(cmd_seen), 128'(2 * N - 1));
        end else begin
          k   = cmd_seen % N;
          rdf = (cmd_seen >= N);
          ec  = exp_cmd(k, rdf);
          check_val("cmd", 128'(command), 128'(ec));
          check_val("bank_rdy", 128'(pm_applied[ec[2:0]]), 128'(1));
          if (cmd_seen == 5) check_val("cmd_k5", 128'(command), 128'(K5_CMD));
          key = int'({command[33:32], command[29:17], command[12:0]});
          if (!rdf) begin
            check_val("wdata", write_data, exp_data(k));
            mem[key] = write_data;
          end else begin
            check_val("rd_wdata", write_data, 128'd0);
            r.d   = mem.exists(key) ? mem[key] : 128'd0;
            lat   = int'($urandom_range(2, 6));
            r.due = cyc + lat;
            if (q.size() > 0 && r.due <= q[$].due) r.due = q[$].due + 1;
            q.push_back(r);
          end
        end
        cmd_seen++;
      end else begin
        check_val("idle_out", 128'(command) | write_data, 128'd0);
      end

      case (pm_mode)
        0:       ba_cmd_pm = 8'hFF;
        1:       ba_cmd_pm = (ba_cmd_pm == 8'hAA) ? 8'h55 : 8'hAA;
        default: ba_cmd_pm = 8'($urandom_range(0, 255));
      endcase
      pm_applied = ba_cmd_pm;

      read_data_valid = 1'b0;
      if (inject_spur) begin
        read_data_valid = 1'b1;
        read_data       = {$urandom(), $urandom(), $urandom(), $urandom()};
        last_rdv_cyc    = cyc;
        inject_spur     = 1'b0;
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        r = q.pop_front();
        if (beats_out == flip_beat) r.d[0] = ~r.d[0];
        if (!(drop_last && beats_out == N - 1)) begin
          read_data_valid = 1'b1;
          read_data       = r.d;
          last_rdv_cyc    = cyc;
        end
        beats_out++;
      end
    end
  end

  task automatic clear_model();
    cmd_seen  = 0;
    beats_out = 0;
    q.delete();
    mem.delete();
  endtask

  task automatic run_test(input string name, input int mode, input int flip, input bit drop,
                          input bit poke, input logic [15:0] e_err, input logic [31:0] e_first,
                          input bit e_to, input bit e_pass);
    bit got_done;
    pm_mode   = mode;
    flip_beat = flip;
    drop_last = drop;
    clear_model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val({name, "_busy"}, 128'(busy), 128'(1));
    check_val({name, "_done_clr"}, 128'(done), 128'(0));
    got_done = 1'b0;
    for (int i = 0; i < 20000 && !got_done; i++) begin
      @(negedge clk);
      start = (poke && i == 8);
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check_val({name, "_done"}, 128'(done), 128'(1));
    check_val({name, "_pass"}, 128'(pass), 128'(e_pass));
    check_val({name, "_errcnt"}, 128'(error_cnt), 128'(e_err));
    check_val({name, "_firsterr"}, 128'(first_err_idx), 128'(e_first));
    check_val({name, "_timeout"}, 128'(timeout), 128'(e_to));
    check_val({name, "_busy_end"}, 128'(busy), 128'(0));
    check_val({name, "_ncmd"}, 128'(cmd_seen), 128'(2 * N));
    check_val({name, "_nbeat"}, 128'(beats_out), 128'(N));
    if (e_to) begin
      check_val({name, "_wait"},
                128'((cyc - last_rdv_cyc) >= TO && (cyc - last_rdv_cyc) <= TO + 8), 128'(1));
    end
  endtask

  initial begin : main
    power_on_rst_n = 1'b0;
    start          = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_valid", 128'(valid), 128'(0));
    check_val("rst_cmd", 128'(command), 128'(0));
    check_val("rst_busy", 128'(busy), 128'(0));
    check_val("rst_done", 128'(done), 128'(0));
    check_val("rst_pass", 128'(pass), 128'(0));
    check_val("rst_timeout", 128'(timeout), 128'(0));
    check_val("rst_errcnt", 128'(error_cnt), 128'(0));
    check_val("rst_firsterr", 128'(first_err_idx), 128'(32'hFFFF_FFFF));
    power_on_rst_n = 1'b1;
    @(negedge clk);

    run_test("loopback", 0, -1, 1'b0, 1'b0, 16'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);

    // A beat while DONE has no read outstanding: spurious, counted, no capture.
    inject_spur = 1'b1;
    repeat (3) @(negedge clk);
    check_val("spur_errcnt", 128'(error_cnt), 128'(1));
    check_val("spur_pass", 128'(pass), 128'(0));
    check_val("spur_firsterr", 128'(first_err_idx), 128'(32'hFFFF_FFFF));
    check_val("spur_done", 128'(done), 128'(1));

    run_test("flip3", 0, 2, 1'b0, 1'b0, 16'd1, 32'd2, 1'b0, 1'b0);
    run_test("toggle", 1, -1, 1'b0, 1'b0, 16'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_test("random", 2, -1, 1'b0, 1'b1, 16'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_test("droplast", 0, -1, 1'b1, 1'b0, 16'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Abort a run partway through the read phase with reset.
    pm_mode   = 0;
    flip_beat = -1;
    drop_last = 1'b0;
    clear_model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && cmd_seen < N + 4; i++) @(negedge clk);
    check_val("midrd_reached", 128'(cmd_seen >= N + 4), 128'(1));
    power_on_rst_n = 1'b0;
    @(negedge clk);
    check_val("midrst_valid", 128'(valid), 128'(0));
    check_val("midrst_cmd", 128'(command), 128'(0));
    check_val("midrst_busy", 128'(busy), 128'(0));
    check_val("midrst_done", 128'(done), 128'(0));
    check_val("midrst_errcnt", 128'(error_cnt), 128'(0));
    check_val("midrst_firsterr", 128'(first_err_idx), 128'(32'hFFFF_FFFF));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("midrst_noval", 128'(valid), 128'(0));
    end
    clear_model();
    repeat (2) @(negedge clk);
    power_on_rst_n = 1'b1;
    @(negedge clk);
    run_test("post_rst", 2, -1, 1'b0, 1'b0, 16'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
